// File: rtl/mips_pipe_pkg.sv
// Shared pipeline types: scoreboard entry layout and result-ready stage encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pipe_pkg;

  // Storage widths for an entry. They cover every legal AW / DEPTH so the struct stays fixed.
  localparam int SB_AW_MAX = 8;
  localparam int SB_RDYW   = 3;

  // Forwarding select value meaning "read the register file".
  localparam int FWD_RF = 0;

  // Stage at whose end the result exists. control_unit drives id_rdy with these.
  localparam logic [SB_RDYW-1:0] RDY_ALU  = 3'd1;
  localparam logic [SB_RDYW-1:0] RDY_LOAD = 3'd2;

  typedef struct packed {
    logic                 valid;
    logic [SB_AW_MAX-1:0] dest;
    logic                 we;
    logic [SB_RDYW-1:0]   rdy;
  } sb_entry_t;

  // A ready stage of 0 means the same as an ALU result.
  function automatic logic [SB_RDYW-1:0] rdy_clamp(input logic [SB_RDYW-1:0] r);
    return (r == '0) ? RDY_ALU : r;
  endfunction

endpackage

// File: rtl/sb_src_match.sv
// Youngest-producer priority encoder for one ID-stage source operand.
// Latency: combinational.
// Backpressure: none; reports hazard so the caller can stall.
module sb_src_match
  import mips_pipe_pkg::*;
#(
  parameter int AW    = 5,
  parameter int DEPTH = 3,
  parameter int SW    = 2
) (
  input  sb_entry_t        ent [DEPTH],
  input  logic [AW-1:0]    src,
  input  logic             used,
  output logic             hit,
  output logic [SW-1:0]    k,
  output logic             hazard
);

  // Scan oldest to youngest so the lowest stage index is the one left standing.
  always_comb begin
    hit    = 1'b0;
    k      = '0;
    hazard = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (used && ent[i].valid && ent[i].we && (src != '0) &&
          (ent[i].dest == SB_AW_MAX'(src))) begin
        hit    = 1'b1;
        k      = SW'(i + 1);
        hazard = (i + 1) < int'(ent[i].rdy);
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Shadow pipeline of in-flight producers: load-use stall, wrong-path flush, EX forwarding selects.
// Latency: stall combinational; fwd_a/fwd_b registered, valid in the consumer's EX cycle.
// Backpressure: hold freezes all state; stall asks ID to hold. Optional SB_PERF_EN adds counters.
module hazard_scoreboard
  import mips_pipe_pkg::*;
#(
  parameter int AW    = 5,
  parameter int DEPTH = 3,
  parameter int LATW  = 2,
  localparam int SW   = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [AW-1:0]   id_rs,
  input  logic [AW-1:0]   id_rt,
  input  logic            id_rs_used,
  input  logic            id_rt_used,
  input  logic [AW-1:0]   id_rd,
  input  logic            id_we,
  input  logic [LATW-1:0] id_rdy,
  input  logic            hold,
  input  logic            flush,
  output logic            stall,
  output logic [SW-1:0]   fwd_a,
  output logic [SW-1:0]   fwd_b,
  output logic            sb_busy
`ifdef SB_PERF_EN
  ,
  output logic [31:0]     perf_stalls,
  output logic [31:0]     perf_fwds
`endif
);

  // ent[i] holds shadow stage i+1 (ent[0] = EX, ent[DEPTH-1] = WB).
  sb_entry_t       ent [DEPTH];
  sb_entry_t       new_ent;
  logic            hit_a, hit_b, haz_a, haz_b, stall_raw;
  logic [SW-1:0]   k_a, k_b, nxt_fwd_a, nxt_fwd_b;

  sb_src_match #(.AW(AW), .DEPTH(DEPTH), .SW(SW)) u_match_a (
    .ent(ent), .src(id_rs), .used(id_rs_used), .hit(hit_a), .k(k_a), .hazard(haz_a)
  );

  sb_src_match #(.AW(AW), .DEPTH(DEPTH), .SW(SW)) u_match_b (
    .ent(ent), .src(id_rt), .used(id_rt_used), .hit(hit_b), .k(k_b), .hazard(haz_b)
  );

  // Stall decision, next forwarding selects (WB match reads the written-through reg file) and new entry.
  always_comb begin
    stall_raw     = id_valid & (haz_a | haz_b);
    stall         = stall_raw & ~flush;
    nxt_fwd_a     = (hit_a && int'(k_a) < DEPTH) ? k_a : SW'(FWD_RF);
    nxt_fwd_b     = (hit_b && int'(k_b) < DEPTH) ? k_b : SW'(FWD_RF);
    new_ent.valid = id_valid & id_we;
    new_ent.dest  = SB_AW_MAX'(id_rd);
    new_ent.we    = id_we;
    new_ent.rdy   = rdy_clamp(SB_RDYW'(id_rdy));
  end

  // Any live producer in the shadow pipe.
  always_comb begin
    sb_busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) sb_busy = sb_busy | ent[i].valid;
  end

  // Advance the shadow pipe; flush kills the EX producer as it moves on, stall inserts a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      fwd_a <= '0;
      fwd_b <= '0;
    end else if (!hold) begin
      for (int i = DEPTH - 1; i > 0; i--) ent[i] <= ent[i-1];
      if (flush) begin
        ent[1].valid <= 1'b0;
        ent[0]       <= '0;
        fwd_a        <= '0;
        fwd_b        <= '0;
      end else if (stall_raw) begin
        ent[0] <= '0;
        fwd_a  <= '0;
        fwd_b  <= '0;
      end else begin
        ent[0] <= new_ent;
        fwd_a  <= nxt_fwd_a;
        fwd_b  <= nxt_fwd_b;
      end
    end
  end

`ifdef SB_PERF_EN
  // Saturating event counters: stall cycles, and real issues that pick up a forwarded operand.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stalls <= '0;
      perf_fwds   <= '0;
    end else if (!hold) begin
      if (stall && perf_stalls != '1) perf_stalls <= perf_stalls + 32'd1;
      if (id_valid && !flush && !stall_raw && (nxt_fwd_a != '0 || nxt_fwd_b != '0) &&
          perf_fwds != '1)
        perf_fwds <= perf_fwds + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed-vector bench for hazard_scoreboard with DEPTH=3, AW=5.
// Latency: inputs driven 1ns after posedge, outputs sampled 1ns after posedge.
// Backpressure: exercises hold, flush and load-use stall.
module tb_hazard_scoreboard;

  localparam int AW = 5, DEPTH = 3, LATW = 2, SW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            id_valid, id_rs_used, id_rt_used, id_we, hold, flush;
  logic [AW-1:0]   id_rs, id_rt, id_rd;
  logic [LATW-1:0] id_rdy;
  logic            stall, sb_busy;
  logic [SW-1:0]   fwd_a, fwd_b;
`ifdef SB_PERF_EN
  logic [31:0]     perf_stalls, perf_fwds;
`endif

  int n_vec = 0;
  int n_err = 0;

  hazard_scoreboard #(.AW(AW), .DEPTH(DEPTH), .LATW(LATW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_we(id_we),
    .id_rdy(id_rdy), .hold(hold), .flush(flush), .stall(stall), .fwd_a(fwd_a),
    .fwd_b(fwd_b), .sb_busy(sb_busy)
`ifdef SB_PERF_EN
    , .perf_stalls(perf_stalls), .perf_fwds(perf_fwds)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                       input logic rsu, input logic rtu, input logic [AW-1:0] rd,
                       input logic we, input logic [LATW-1:0] rdy);
    id_valid   = v;
    id_rs      = rs;
    id_rt      = rt;
    id_rs_used = rsu;
    id_rt_used = rtu;
    id_rd      = rd;
    id_we      = we;
    id_rdy     = rdy;
    #1;
  endtask

  task automatic nop();
    issue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0);
  endtask

  initial begin
    reset = 1'b0;
    hold  = 1'b0;
    flush = 1'b0;
    nop();
    #10;
    chk("rst_busy", 32'(sb_busy), 32'd0);
    chk("rst_fwd_a", 32'(fwd_a), 32'd0);
    chk("rst_fwd_b", 32'(fwd_b), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    tick();
    reset = 1'b1;

    // 1: add r3,r1,r2 ; add r4,r3,r1 -> forward from stage 2
    issue(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 2'd1);
    tick();
    chk("t1_prod_fwd_a", 32'(fwd_a), 32'd0);
    issue(1, 5'd3, 5'd1, 1, 1, 5'd4, 1, 2'd1);
    chk("t1_stall", 32'(stall), 32'd0);
    tick();
    chk("t1_fwd_a", 32'(fwd_a), 32'd1);
    chk("t1_fwd_b", 32'(fwd_b), 32'd0);

    // 2: lw r5,0(r4) ; add r6,r5,r0 -> one stall, then forward from stage 3
    issue(1, 5'd4, 5'd0, 1, 0, 5'd5, 1, 2'd2);
    tick();
    chk("t2_lw_fwd_a", 32'(fwd_a), 32'd1);
    issue(1, 5'd5, 5'd0, 1, 1, 5'd6, 1, 2'd1);
    chk("t2_stall", 32'(stall), 32'd1);
    tick();
    chk("t2_bub_fwd_a", 32'(fwd_a), 32'd0);
    chk("t2_bub_fwd_b", 32'(fwd_b), 32'd0);
    chk("t2_stall_clr", 32'(stall), 32'd0);
    tick();
    chk("t2_fwd_a", 32'(fwd_a), 32'd2);
    chk("t2_fwd_b", 32'(fwd_b), 32'd0);
    // lw now at WB (reg file), add r6 at EX (stage 1)
    issue(1, 5'd5, 5'd6, 1, 1, 5'd10, 1, 2'd1);
    chk("t2_wb_stall", 32'(stall), 32'd0);
    tick();
    chk("t2_wb_fwd_a", 32'(fwd_a), 32'd0);
    chk("t2_wb_fwd_b", 32'(fwd_b), 32'd1);

    // 3: writer to r0 then reader of r0 -> never a hazard
    issue(1, 5'd0, 5'd0, 1, 1, 5'd0, 1, 2'd2);
    tick();
    issue(1, 5'd0, 5'd0, 1, 1, 5'd7, 1, 2'd1);
    chk("t3_stall", 32'(stall), 32'd0);
    tick();
    chk("t3_fwd_a", 32'(fwd_a), 32'd0);
    chk("t3_fwd_b", 32'(fwd_b), 32'd0);
    // youngest producer of r9 wins over the older one
    issue(1, 5'd10, 5'd0, 1, 0, 5'd9, 1, 2'd1);
    tick();
    issue(1, 5'd7, 5'd0, 1, 0, 5'd9, 1, 2'd1);
    tick();
    chk("t3_r9b_fwd_a", 32'(fwd_a), 32'd2);
    issue(1, 5'd9, 5'd9, 1, 1, 5'd11, 1, 2'd1);
    tick();
    chk("t3_young_fwd_a", 32'(fwd_a), 32'd1);
    chk("t3_young_fwd_b", 32'(fwd_b), 32'd1);
    nop();
    tick();
    tick();
    chk("t3_busy_drain", 32'(sb_busy), 32'd1);
    tick();
    chk("t3_busy_empty", 32'(sb_busy), 32'd0);

    // 4: add r12 ; lw r8 ; beq r8 flushed in the would-be stall cycle
    issue(1, 5'd0, 5'd0, 0, 0, 5'd12, 1, 2'd1);
    tick();
    issue(1, 5'd0, 5'd0, 0, 0, 5'd8, 1, 2'd2);
    tick();
    issue(1, 5'd8, 5'd0, 1, 0, 5'd0, 0, 2'd1);
    chk("t4_stall_noflush", 32'(stall), 32'd1);
    flush = 1'b1;
    #1;
    chk("t4_stall_flush", 32'(stall), 32'd0);
    tick();
    flush = 1'b0;
    nop();
    chk("t4_fwd_a", 32'(fwd_a), 32'd0);
    chk("t4_busy_old", 32'(sb_busy), 32'd1);
    tick();
    chk("t4_busy_low", 32'(sb_busy), 32'd0);

    // 5: add r13 ; add r14,r13 ; hold 3 cycles with add r15,r14,r13 waiting
    issue(1, 5'd0, 5'd0, 0, 0, 5'd13, 1, 2'd1);
    tick();
    issue(1, 5'd13, 5'd0, 1, 0, 5'd14, 1, 2'd1);
    tick();
    chk("t5_pre_fwd_a", 32'(fwd_a), 32'd1);
    issue(1, 5'd14, 5'd13, 1, 1, 5'd15, 1, 2'd1);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("t5_hold_fwd_a", 32'(fwd_a), 32'd1);
    chk("t5_hold_fwd_b", 32'(fwd_b), 32'd0);
    chk("t5_hold_busy", 32'(sb_busy), 32'd1);
    hold = 1'b0;
    tick();
    chk("t5_resume_fwd_a", 32'(fwd_a), 32'd1);
    chk("t5_resume_fwd_b", 32'(fwd_b), 32'd2);

`ifdef SB_PERF_EN
    chk("perf_stalls", perf_stalls, 32'd1);
    chk("perf_fwds", perf_fwds, 32'd8);
`endif

    // 6: asynchronous reset with three live entries, checked before the next clock
    nop();
    #2;
    reset = 1'b0;
    #1;
    chk("t6_busy", 32'(sb_busy), 32'd0);
    chk("t6_fwd_a", 32'(fwd_a), 32'd0);
    chk("t6_fwd_b", 32'(fwd_b), 32'd0);
`ifdef SB_PERF_EN
    chk("t6_perf_stalls", perf_stalls, 32'd0);
    chk("t6_perf_fwds", perf_fwds, 32'd0);
`endif
    tick();
    reset = 1'b1;
    tick();
    chk("t6_busy_after", 32'(sb_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
